// File: rtl/writeback_unit_if.sv
// writeback_unit_if: execute-result, data-memory and register-write signals of the writeback stage
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;
  logic            regwrite;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic            wb_err;
  modport slave (
    input  ex_valid, ex_opcode, ex_funct3, ex_rd, ex_alu_result, ex_imm, ex_pc,
    input  mem_rdata, mem_rvalid,
    output ex_ready, regwrite, write_reg, write_data, wb_err
  );
  modport master (
    output ex_valid, ex_opcode, ex_funct3, ex_rd, ex_alu_result, ex_imm, ex_pc,
    output mem_rdata, mem_rvalid,
    input  ex_ready, regwrite, write_reg, write_data, wb_err
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage selecting the writeback value and issuing one registered register-file write per instruction.
// Optional build macro WB_LOAD_EXT_EN: byte/half-word extraction and sign/zero extension of load data.
module writeback_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic              i_clock,
  input logic              i_reset,
  writeback_unit_if.slave  io_wb
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_cnt;
  logic [4:0]      r_ld_rd;
  logic            r_regwrite, r_wb_err;
  logic [4:0]      r_write_reg;
  logic [XLEN-1:0] r_write_data;
  logic            w_ready, w_xfer, w_is_load, w_we, w_timeout;
  logic [XLEN-1:0] w_val, w_ld;
`ifdef WB_LOAD_EXT_EN
  logic [2:0]      r_ld_f3;
  logic [1:0]      r_ld_off;
  logic [7:0]      w_b;
  logic [15:0]     w_h;
`endif
  assign w_xfer            = io_wb.ex_valid && w_ready;
  assign w_is_load         = io_wb.ex_opcode == 7'b0000011;
  assign w_timeout         = r_cnt == 8'(MEM_TIMEOUT - 1);
  assign io_wb.ex_ready    = w_ready;
  assign io_wb.regwrite    = r_regwrite;
  assign io_wb.write_reg   = r_write_reg;
  assign io_wb.write_data  = r_write_data;
  assign io_wb.wb_err      = r_wb_err;
  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state: a load parks in WAIT_MEM until data or timeout; data wins a tie with the timeout
  always_comb begin
    w_next = r_state;
    if (r_state == WAIT_MEM) w_next = io_wb.mem_rvalid ? COMMIT : (w_timeout ? IDLE : WAIT_MEM);
    else w_next = w_xfer ? (w_is_load ? WAIT_MEM : COMMIT) : IDLE;
  end
  // Outputs: readiness and per-opcode writeback value for non-load instructions
  always_comb begin
    w_ready = r_state != WAIT_MEM;
    w_we    = 1'b1;
    w_val   = '0;
    case (io_wb.ex_opcode)
      7'b0110011, 7'b0010011: w_val = io_wb.ex_alu_result;
      7'b1101111, 7'b1100111: w_val = io_wb.ex_pc + XLEN'(4);
      7'b0110111:             w_val = io_wb.ex_imm;
      7'b0010111:             w_val = io_wb.ex_pc + io_wb.ex_imm;
      default:                w_we  = 1'b0;
    endcase
  end
`ifdef WB_LOAD_EXT_EN
  // Load data: lane select by captured address offset, then extend per captured funct3
  always_comb begin
    w_b  = 8'(io_wb.mem_rdata >> {r_ld_off, 3'b000});
    w_h  = 16'(io_wb.mem_rdata >> {r_ld_off[1], 4'b0000});
    w_ld = r_ld_f3 == 3'b000 ? {{(XLEN-8){w_b[7]}}, w_b} :
           r_ld_f3 == 3'b001 ? {{(XLEN-16){w_h[15]}}, w_h} :
           r_ld_f3 == 3'b100 ? {{(XLEN-8){1'b0}}, w_b} :
           r_ld_f3 == 3'b101 ? {{(XLEN-16){1'b0}}, w_h} : io_wb.mem_rdata;
  end
`else
  assign w_ld = io_wb.mem_rdata;
`endif
  // Registered write port, error pulse, timeout counter and pending-load context
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_regwrite   <= 1'b0;
      r_wb_err     <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_cnt        <= '0;
      r_ld_rd      <= '0;
`ifdef WB_LOAD_EXT_EN
      r_ld_f3      <= '0;
      r_ld_off     <= '0;
`endif
    end else begin
      r_regwrite <= 1'b0;
      r_wb_err   <= 1'b0;
      if (r_state == WAIT_MEM) begin
        r_cnt <= r_cnt + 8'd1;
        if (io_wb.mem_rvalid) begin
          r_regwrite   <= |r_ld_rd;
          r_write_reg  <= r_ld_rd;
          r_write_data <= w_ld;
        end else if (w_timeout) r_wb_err <= 1'b1;
      end else if (w_xfer && w_is_load) begin
        r_cnt   <= '0;
        r_ld_rd <= io_wb.ex_rd;
`ifdef WB_LOAD_EXT_EN
        r_ld_f3  <= io_wb.ex_funct3;
        r_ld_off <= io_wb.ex_alu_result[1:0];
`endif
      end else if (w_xfer) begin
        r_regwrite   <= w_we && |io_wb.ex_rd;
        r_write_reg  <= io_wb.ex_rd;
        r_write_data <= w_val;
      end
    end
  end
endmodule
